mod_updown_counter: RTL
=======================

Name: mod_updown_counter

Overview:
- Parametrised synchronous successor to the 4-bit ripple counter. Provides a WIDTH-bit counter with a programmable modulus, up/down direction, enable, synchronous load and synchronous clear.
- Provides terminal-count and wrap flags for cascading and event generation.
- All flops sit in the single clk domain, so downstream logic sees no ripple skew.
- Used as the general-purpose event/divider counter in timer and prescaler paths.

Parameters:
- WIDTH, 8, counter width in bits (≥2).
- MAX_VALUE, 2**WIDTH-1, highest count value. Count range is 0..MAX_VALUE (modulus MAX_VALUE+1). Must be ≤ 2**WIDTH-1 and ≥1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  count enable. One step per clk edge while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value captured on load.
- clr  input  1  synchronous clear to 0.
- q  output  WIDTH  registered count.
- tc  output  1  combinational terminal count: en && ((up_dn && q==MAX_VALUE) || (!up_dn && q==0)).
- zero  output  1  combinational q==0.
- wrap  output  1  registered one-cycle pulse, high in the cycle after q wrapped.

Behaviour:
- Reset:
  - reset_n low → q=0, wrap=0 immediately, independent of clk.
  - Release is synchronous to the design flow. The first count step occurs on the first clk edge with reset_n high.
- Priority per edge: clr > load > en. Lower-priority requests in the same cycle are ignored.
- clr=1 → q←0, wrap←0.
- load=1 (clr=0):
  - q←load_val if load_val ≤ MAX_VALUE, else q←MAX_VALUE (clamp).
  - wrap←0.
- en=1 (clr=0, load=0):
  - Up: q←q+1; if q==MAX_VALUE, q←0 and wrap←1.
  - Down: q←q-1; if q==0, q←MAX_VALUE and wrap←1.
  - Otherwise wrap←0.
- en=0 (no clr/load): q holds, wrap←0.
- Latency:
  - q updates on the edge the request is sampled.
  - wrap is valid the cycle after the wrapping edge, coincident with the new q (0 or MAX_VALUE).
- tc and zero are pure functions of the current q, en and up_dn, so a cascaded stage can use tc as its en.
- Direction change takes effect on the same edge it is sampled. No hidden state beyond q and wrap.
- Non-power-of-two MAX_VALUE: q never holds a value > MAX_VALUE after reset except through no path (load clamps). The next-state logic must still map any q > MAX_VALUE to 0 on the next enabled step, for robustness.
- Width rules: all arithmetic is WIDTH bits. No carry out other than wrap/tc.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- Defined: counter saturates instead of wrapping.
  - Up at MAX_VALUE holds MAX_VALUE; down at 0 holds 0.
  - wrap stays 0 permanently.
  - tc keeps its definition, so it stays high while pinned at a bound with en=1.
- Undefined: modulo wrap behaviour as above.
- clr/load/reset behaviour is identical in both builds.

Test Plan (WIDTH=4, MAX_VALUE=9 unless noted):
- Reset: q=5 mid-count, pulse reset_n low between clk edges → q=0 and wrap=0 immediately. Counting resumes from 0 on the first edge after release.
- Up wrap: load 8, en=1, up_dn=1 → q=9 (tc=1), then q=0 with wrap=1 for exactly one cycle, then q=1 with wrap=0.
- Down wrap: clr, then en=1, up_dn=0 → tc=1 at q=0, next q=9 with wrap=1. Following edge q=8.
- Priority: assert clr, load (load_val=7) and en together → q=0. Then load=1, load_val=12, en=1 → q=9 (clamped, no count).
- Hold/direction: en=0 for 5 cycles → q unchanged, wrap=0. Toggle up_dn every cycle at q=3 → q alternates 4,3,4,3.
- COUNTER_SATURATE_EN build, WIDTH=4 default MAX_VALUE=15: count up from 14 for 4 edges → q=15,15,15,15, wrap never 1, tc=1 throughout.

Source files
------------

// File: rtl/mod_updown_counter.sv
// WIDTH-bit synchronous up/down counter with modulus MAX_VALUE+1, load, clear and tc/zero/wrap flags.
// Define COUNTER_SATURATE_EN to pin at 0/MAX_VALUE instead of wrapping.
module mod_updown_counter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_VALUE = (2 ** WIDTH) - 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             over_max;
    logic [WIDTH-1:0] load_clamped;

    // A full-range modulus can never exceed MAX_Q, so skip the range compares entirely.
    if (MAX_VALUE == (2 ** WIDTH) - 1) begin : g_full_range
        assign over_max     = 1'b0;
        assign load_clamped = load_val;
    end else begin : g_partial_range
        assign over_max     = (q_q > MAX_Q);
        assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        q_d    = q_q;
        wrap_d = 1'b0;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = load_clamped;
        end else if (en) begin
            if (over_max) begin
                q_d = '0;
            end else if (up_dn) begin
                if (q_q == MAX_Q) begin
`ifdef COUNTER_SATURATE_EN
                    q_d = MAX_Q;
`else
                    q_d    = '0;
                    wrap_d = 1'b1;
`endif
                end else begin
                    q_d = q_q + ONE_Q;
                end
            end else begin
                if (q_q == '0) begin
`ifdef COUNTER_SATURATE_EN
                    q_d = '0;
`else
                    q_d    = MAX_Q;
                    wrap_d = 1'b1;
`endif
                end else begin
                    q_d = q_q - ONE_Q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign zero = (q_q == '0);
    assign tc   = en && ((up_dn && (q_q == MAX_Q)) || (!up_dn && (q_q == '0)));

endmodule
